reg_bank_rom_loader: RTL

//  8 x WIDTH register bank placed directly upstream of the 8:1 word select mux.
//  Its q0..q7 outputs drive the mux data inputs in0..in7 one-to-one.

---
 rtl/reg_bank_rom_loader.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_bank_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_rom_loader
// Description : 8 x WIDTH register bank feeding the 8:1 word select mux
//               (q0..q7 drive mux in0..in7 one-to-one). Out of reset, and on
//               every accepted reload request, a load sequence streams ROM
//               words 0..7 into the bank. Once loaded, the bank runs in RUN
//               and accepts single-word writes every cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      : width of every register, ROM word and write-port word
// Ports
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   rom_rd     : ROM read strobe (registered); data returns the next cycle
//   rom_addr   : ROM word address (registered)
//   rom_data   : ROM read data, valid the cycle after rom_rd
//   reload     : request a fresh ROM load (accepted only when ready=1)
//   wr_en      : register write strobe (accepted only when ready=1)
//   wr_addr    : register index to write
//   wr_data    : write data
//   ready      : 1 while the bank is loaded and writable
//   load_done  : one-cycle pulse in the first ready cycle after each load
//   q0..q7     : register contents, driven straight from flops
// Build option
//   R0_ZERO_EN : when defined, register 0 is held at zero permanently; the
//                ROM word 0 is still fetched but discarded and writes to
//                index 0 are ignored. Load timing is unaffected.
// Load timing (edge 1 = first rising clk after reset release or reload)
//   edges 1..8 : rom_rd=1 with rom_addr 0..7 visible in cycles 1..8
//   edge 9     : rom_rd drops, rom_addr parks at 7
//   edge 10    : word 7 captured, ready=1 and load_done=1 in cycle 10
// ============================================================================
module reg_bank_rom_loader #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             rom_rd,
    output logic [2:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    input  logic             reload,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             ready,
    output logic             load_done,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] S_LOAD   = 1'b0;
    localparam logic [0:0] S_RUN    = 1'b1;
    localparam int         NUM_REGS = 8;
    localparam logic [3:0] CNT_LAST = 4'd8;
    localparam logic [2:0] IDX_LAST = 3'd7;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [3:0]          r_cnt;        // read-issue counter, 0..8
    logic                r_rom_rd;
    logic [2:0]          r_rom_addr;
    // The ROM answers one cycle after it samples rom_rd/rom_addr, so the
    // strobe and address are delayed by one flop stage to know, in the cycle
    // the data is on rom_data, that it is valid and which register it is for.
    logic                r_cap_vld;
    logic [2:0]          r_cap_idx;
    logic                r_ready;
    logic                r_load_done;
    logic [WIDTH-1:0]    r_q [NUM_REGS];

    logic [NUM_REGS-1:0] w_ld_we;      // per-register ROM capture enable
    logic [NUM_REGS-1:0] w_wr_we;      // per-register user write enable
    logic                w_load_last;  // final ROM word is being captured

    assign w_load_last = (r_state == S_LOAD) && r_cap_vld && (r_cap_idx == IDX_LAST);

    // ------------------------------------------------------------------------
    // Load / run sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_rom_rd    <= 1'b0;
            r_rom_addr  <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_idx   <= '0;
            r_ready     <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_cap_vld   <= r_rom_rd;
            r_cap_idx   <= r_rom_addr;
            r_load_done <= 1'b0;

            case (r_state)
                S_LOAD: begin
                    // Reload requests are not looked at here, so a pulse
                    // arriving mid-load cannot restart the sequence.
                    if (r_cnt < CNT_LAST) begin
                        r_rom_rd   <= 1'b1;
                        r_rom_addr <= r_cnt[2:0];
                        r_cnt      <= r_cnt + 4'd1;
                    end else begin
                        // All eight reads issued; address parks at 7.
                        r_rom_rd   <= 1'b0;
                    end

                    if (w_load_last) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        r_ready     <= 1'b1;
                        r_load_done <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (reload) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_LOAD;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register write enables
    // ------------------------------------------------------------------------
    // ROM capture is only possible in LOAD and user writes only in RUN, so
    // the two enable vectors are never active in the same cycle. A reload
    // request takes priority over a write presented in the same cycle.
    always_comb begin
        w_ld_we = '0;
        w_wr_we = '0;

        if ((r_state == S_LOAD) && r_cap_vld) begin
            w_ld_we[r_cap_idx] = 1'b1;
        end

        if ((r_state == S_RUN) && wr_en && !reload) begin
            w_wr_we[wr_addr] = 1'b1;
        end

`ifdef R0_ZERO_EN
        // Register 0 is a hard zero: ROM word 0 and writes to index 0 are
        // discarded, so the flop never leaves its reset value.
        w_ld_we[0] = 1'b0;
        w_wr_we[0] = 1'b0;
`else
        w_ld_we[0] = w_ld_we[0];
        w_wr_we[0] = w_wr_we[0];
`endif
    end

    // ------------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------------
    // Registers not targeted in a given cycle hold, so during a reload the
    // old contents remain visible until each word is individually replaced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_ld_we[i]) begin
                    r_q[i] <= rom_data;
                end else if (w_wr_we[i]) begin
                    r_q[i] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // ------------------------------------------------------------------------
    assign rom_rd    = r_rom_rd;
    assign rom_addr  = r_rom_addr;
    assign ready     = r_ready;
    assign load_done = r_load_done;

    assign q0 = r_q[0];
    assign q1 = r_q[1];
    assign q2 = r_q[2];
    assign q3 = r_q[3];
    assign q4 = r_q[4];
    assign q5 = r_q[5];
    assign q6 = r_q[6];
    assign q7 = r_q[7];

endmodule
`default_nettype wire
